dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencer and arbiter for the single-port data memory used by the MEM stage. It shares the memory between the pipeline MEM stage (port P) and a program/data loader (port L), issues each access and waits a configurable memory latency. It returns read data with a one-cycle acknowledge. While the pipeline's request is pending it stalls the pipeline, and it guarantees the loader forward progress through a bounded-starvation counter.

## Interface
- ADDR_WIDTH, 32, address width of both ports and the memory
- DATA_WIDTH, 32, data width
- MEM_LAT, 1, memory read latency in cycles, ≥1 (1 = read data valid in the issue cycle)
- STARVE_MAX, 4, maximum consecutive contested wins by P before L must be granted, ≥1

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- p_req  in  1  pipeline access request, held until p_ack
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  ADDR_WIDTH  pipeline address
- p_wdata  in  DATA_WIDTH  pipeline write data
- p_ack  out  1  one-cycle completion pulse to P
- p_stall  out  1  p_req & ~p_ack, combinational
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader request, same meaning as the P port
- l_ack  out  1  one-cycle completion pulse to L
- rdata  out  DATA_WIDTH  read data, valid while p_ack or l_ack is high
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write strobe, coincident with mem_en
- mem_addr  out  ADDR_WIDTH  memory address, held for the whole access
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: sample p_req/l_req at each edge.
  - Neither high: stay in IDLE.
  - Exactly one high: grant it.
  - Both high ("contested"): grant P unless starve_cnt == STARVE_MAX, in which case grant L.
- On a grant:
  - Latch the grant id, we, addr and wdata into registers.
  - Load lat_cnt = MEM_LAT − 1.
  - Move to ACCESS.
- Starvation counter:
  - starve_cnt increments on a contested P grant, saturating at STARVE_MAX.
  - It clears to 0 on any L grant.
  - An uncontested P grant leaves it unchanged.
- ACCESS:
  - mem_addr and mem_wdata drive the latched values for every ACCESS cycle.
  - mem_en = 1 and mem_we = latched we only in the first ACCESS cycle.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and move to DONE.
- DONE:
  - Assert the granted requester's ack for exactly one cycle, then return to IDLE.
  - Requests are not sampled in DONE, so a requester that drops req on the edge ending its ack is never re-granted.
- Requester rules:
  - A requester holds req and its payload stable until ack.
  - If req drops early, the latched access still completes and ack still pulses.
- Reset (rst low, asynchronous, including mid-access):
  - State → IDLE.
  - starve_cnt, lat_cnt, grant → 0.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, rdata, p_ack, l_ack, busy.
  - An aborted write may or may not have reached memory. An aborted access is never acknowledged.

## Timing
- Cycle 0: req high, state IDLE.
- Cycles 1..MEM_LAT: ACCESS; mem_en/mem_we high in cycle 1 only.
- Cycle MEM_LAT+1: DONE, ack and rdata valid.
- Cycle MEM_LAT+2: IDLE, next request sampled.
- Request-to-ack latency is MEM_LAT+1 cycles. Peak throughput is one access per MEM_LAT+2 cycles.
- p_stall is high from cycle 0 through cycle MEM_LAT and low in the ack cycle.
- Counter widths: lat_cnt uses $clog2(MEM_LAT+1) bits; starve_cnt uses $clog2(STARVE_MAX+1) bits.
- rdata holds its last captured value outside ack cycles.

## Test plan
- Single P read, MEM_LAT=1, memory pre-loaded 0xDEADBEEF at 0x10:
  - Expected: mem_en pulse in cycle 1, p_ack and rdata=0xDEADBEEF in cycle 2, p_stall high in cycles 0–1.
- L write 0x12345678 to 0x20, then P read 0x20, MEM_LAT=3:
  - mem_we pulses once (write issue cycle 1); l_ack in cycle 4.
  - P read (req in cycle 5): p_ack in cycle 9 with rdata=0x12345678.
- Both requesters held high continuously, STARVE_MAX=4:
  - Grant order is P,P,P,P,L,P,P,P,P,L.
  - starve_cnt returns to 0 after each L grant.
- P req asserted while L access is in ACCESS:
  - P is granted only after l_ack, in the IDLE cycle that follows.
  - p_stall stays high throughout the wait.
- rst pulled low in the second ACCESS cycle of an access with MEM_LAT=3:
  - All outputs go 0 immediately; no ack is produced.
  - After release, a held p_req is granted from IDLE with full latency.
- P drops p_req in cycle 1 of its access:
  - p_ack still pulses in cycle MEM_LAT+1.
  - No second access is issued.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between the pipeline MEM stage (port P)
//   and a program/data loader (port L). Each granted access is issued to the
//   memory once, the arbiter waits MEM_LAT cycles for read data, then returns
//   a one-cycle acknowledge to the granted requester. P wins contested
//   arbitration until it has won STARVE_MAX contested rounds in a row, after
//   which L is granted.
//
// Ports
//   clk, rst                        clock (rising edge), async active-low reset
//   p_req/p_we/p_addr/p_wdata       pipeline request and payload
//   p_ack, p_stall                  pipeline completion pulse, stall
//   l_req/l_we/l_addr/l_wdata       loader request and payload
//   l_ack                           loader completion pulse
//   rdata                           read data, valid with p_ack/l_ack
//   mem_en/mem_we                   memory strobes, first access cycle only
//   mem_addr/mem_wdata              memory address/write data, held per access
//   mem_rdata                       memory read data
//   busy                            arbiter not idle
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_req,
  input  logic                  p_we,
  input  logic [ADDR_WIDTH-1:0] p_addr,
  input  logic [DATA_WIDTH-1:0] p_wdata,
  output logic                  p_ack,
  output logic                  p_stall,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int LAT_W    = $clog2(MEM_LAT + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [LAT_W-1:0]    LAT_LOAD     = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;   // 0 = P, 1 = L
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [LAT_W-1:0]      lat_cnt_reg, lat_cnt_next;
  logic [STARVE_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

  logic contested;
  logic take_l;

  assign contested = p_req & l_req;
  // L wins when it is alone, or when P has used up its contested wins.
  assign take_l    = l_req & (~p_req | (starve_cnt_reg == STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      rdata_reg      <= rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    rdata_next      = rdata_reg;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    p_ack           = 1'b0;
    l_ack           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (p_req || l_req) begin
          grant_next   = take_l;
          we_next      = take_l ? l_we    : p_we;
          addr_next    = take_l ? l_addr  : p_addr;
          wdata_next   = take_l ? l_wdata : p_wdata;
          lat_cnt_next = LAT_LOAD;
          state_next   = ACCESS;
          if (take_l) begin
            starve_cnt_next = '0;
          end else if (contested && (starve_cnt_reg != STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
          end
        end
      end

      ACCESS: begin
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
        // The counter is loaded with LAT_LOAD and only counts down, so it
        // equals LAT_LOAD exactly once: the issue cycle.
        if (lat_cnt_reg == LAT_LOAD) begin
          mem_en = 1'b1;
          mem_we = we_reg;
        end
        if (lat_cnt_reg == '0) begin
          if (!we_reg) begin
            rdata_next = mem_rdata;
          end
          state_next = DONE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 1'b1;
        end
      end

      DONE: begin
        p_ack      = ~grant_reg;
        l_ack      = grant_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign p_stall = p_req & ~p_ack;
  assign busy    = (state_reg != IDLE);
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. Two instances share clock and reset:
// u_dut1 (MEM_LAT=1) backed by a small ROM, u_dut3 (MEM_LAT=3) backed by a RAM.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic          p_req1, p_we1, l_req1, l_we1;
  logic [AW-1:0] p_addr1, l_addr1, mem_addr1;
  logic [DW-1:0] p_wdata1, l_wdata1, mem_wdata1, mem_rdata1, rdata1;
  logic          p_ack1, p_stall1, l_ack1, mem_en1, mem_we1, busy1;

  // MEM_LAT = 3 instance
  logic          p_req3, p_we3, l_req3, l_we3;
  logic [AW-1:0] p_addr3, l_addr3, mem_addr3;
  logic [DW-1:0] p_wdata3, l_wdata3, mem_wdata3, mem_rdata3, rdata3;
  logic          p_ack3, p_stall3, l_ack3, mem_en3, mem_we3, busy3;

  logic [DW-1:0] rom1 [0:255];
  logic [DW-1:0] ram3 [0:255];

  assign mem_rdata1 = rom1[mem_addr1[7:0]];
  assign mem_rdata3 = ram3[mem_addr3[7:0]];

  always @(posedge clk) begin
    if (mem_en3 && mem_we3) ram3[mem_addr3[7:0]] <= mem_wdata3;
  end

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .p_req(p_req1), .p_we(p_we1), .p_addr(p_addr1), .p_wdata(p_wdata1),
    .p_ack(p_ack1), .p_stall(p_stall1),
    .l_req(l_req1), .l_we(l_we1), .l_addr(l_addr1), .l_wdata(l_wdata1),
    .l_ack(l_ack1), .rdata(rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .p_req(p_req3), .p_we(p_we3), .p_addr(p_addr3), .p_wdata(p_wdata3),
    .p_ack(p_ack3), .p_stall(p_stall3),
    .l_req(l_req3), .l_we(l_we3), .l_addr(l_addr3), .l_wdata(l_wdata3),
    .l_ack(l_ack3), .rdata(rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one more time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy1, p_ack1, l_ack1, mem_en1, mem_we1} !== 5'b0) begin bad++; $display("FAIL reset_ctrl1: got %b want 00000", {busy1, p_ack1, l_ack1, mem_en1, mem_we1}); end
    total++; if ({mem_addr1, mem_wdata1, rdata1} !== 96'h0) begin bad++; $display("FAIL reset_data1: got %h want 0", {mem_addr1, mem_wdata1, rdata1}); end
    total++; if ({busy3, p_ack3, l_ack3, mem_en3, mem_we3} !== 5'b0) begin bad++; $display("FAIL reset_ctrl3: got %b want 00000", {busy3, p_ack3, l_ack3, mem_en3, mem_we3}); end
    total++; if (u_dut3.starve_cnt_reg !== 3'd0) begin bad++; $display("FAIL reset_starve: got %0d want 0", u_dut3.starve_cnt_reg); end
    rst = 1'b1;
    $display("reset: outputs idle");
  endtask

  task automatic test_p_read_lat1();
    tick();  // cycle 0
    p_req1 = 1'b1; p_we1 = 1'b0; p_addr1 = 32'h10;
    #1;
    total++; if (p_stall1 !== 1'b1) begin bad++; $display("FAIL lat1_stall_c0: got %b want 1", p_stall1); end
    tick(); #1;  // cycle 1
    total++; if ({mem_en1, mem_we1} !== 2'b10) begin bad++; $display("FAIL lat1_en_c1: got %b want 10", {mem_en1, mem_we1}); end
    total++; if (mem_addr1 !== 32'h10) begin bad++; $display("FAIL lat1_addr_c1: got %h want 10", mem_addr1); end
    total++; if ({p_stall1, p_ack1} !== 2'b10) begin bad++; $display("FAIL lat1_stall_c1: got %b want 10", {p_stall1, p_ack1}); end
    tick(); #1;  // cycle 2
    total++; if ({p_ack1, p_stall1, mem_en1} !== 3'b100) begin bad++; $display("FAIL lat1_ack_c2: got %b want 100", {p_ack1, p_stall1, mem_en1}); end
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL lat1_rdata: got %h want deadbeef", rdata1); end
    p_req1 = 1'b0;
    tick(); #1;  // cycle 3
    total++; if ({p_ack1, busy1} !== 2'b00) begin bad++; $display("FAIL lat1_after: got %b want 00", {p_ack1, busy1}); end
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL lat1_rdata_hold: got %h want deadbeef", rdata1); end
    $display("P read lat1 addr 10 -> %h", rdata1);
  endtask

  task automatic test_l_write_p_read();
    int we_cnt;
    we_cnt = 0;
    tick();  // cycle 0
    l_req3 = 1'b1; l_we3 = 1'b1; l_addr3 = 32'h20; l_wdata3 = 32'h12345678;
    #1;
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL wr_busy_c0: got %b want 0", busy3); end
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      if (mem_we3) we_cnt++;
      if (c == 1) begin
        total++; if ({mem_en3, mem_we3} !== 2'b11) begin bad++; $display("FAIL wr_strobe_c1: got %b want 11", {mem_en3, mem_we3}); end
        total++; if ({mem_addr3, mem_wdata3} !== {32'h20, 32'h12345678}) begin bad++; $display("FAIL wr_payload: got %h want 0000002012345678", {mem_addr3, mem_wdata3}); end
      end
      if (c == 3) begin
        total++; if (mem_addr3 !== 32'h20) begin bad++; $display("FAIL wr_addr_hold: got %h want 20", mem_addr3); end
      end
      if (c < 4) begin
        total++; if (l_ack3 !== 1'b0) begin bad++; $display("FAIL wr_early_ack c%0d: got %b want 0", c, l_ack3); end
      end else begin
        total++; if ({l_ack3, p_ack3} !== 2'b10) begin bad++; $display("FAIL wr_ack_c4: got %b want 10", {l_ack3, p_ack3}); end
        total++; if (rdata3 !== 32'h0) begin bad++; $display("FAIL wr_rdata_unchanged: got %h want 0", rdata3); end
      end
    end
    total++; if (we_cnt != 1) begin bad++; $display("FAIL wr_we_pulses: got %0d want 1", we_cnt); end
    l_req3 = 1'b0; l_we3 = 1'b0;
    $display("L write addr 20 data 12345678");

    tick();  // cycle 5
    p_req3 = 1'b1; p_we3 = 1'b0; p_addr3 = 32'h20;
    #1;
    total++; if ({busy3, p_stall3} !== 2'b01) begin bad++; $display("FAIL rd_c5: got %b want 01", {busy3, p_stall3}); end
    for (int c = 6; c <= 9; c++) begin
      tick(); #1;
      if (c < 9) begin
        total++; if ({p_stall3, p_ack3} !== 2'b10) begin bad++; $display("FAIL rd_wait c%0d: got %b want 10", c, {p_stall3, p_ack3}); end
      end else begin
        total++; if ({p_ack3, p_stall3} !== 2'b10) begin bad++; $display("FAIL rd_ack_c9: got %b want 10", {p_ack3, p_stall3}); end
        total++; if (rdata3 !== 32'h12345678) begin bad++; $display("FAIL rd_rdata: got %h want 12345678", rdata3); end
      end
    end
    p_req3 = 1'b0;
    tick(); #1;  // cycle 10
    total++; if ({p_ack3, busy3} !== 2'b00) begin bad++; $display("FAIL rd_after: got %b want 00", {p_ack3, busy3}); end
    total++; if (rdata3 !== 32'h12345678) begin bad++; $display("FAIL rd_hold: got %h want 12345678", rdata3); end
    $display("P read addr 20 -> %h", rdata3);
  endtask

  task automatic test_starvation();
    logic       found;
    logic       exp_l;
    logic [2:0] exp_cnt;
    tick();
    p_req3 = 1'b1; l_req3 = 1'b1; p_we3 = 1'b0; l_we3 = 1'b0;
    p_addr3 = 32'h30; l_addr3 = 32'h40;
    for (int g = 0; g < 10; g++) begin
      exp_l   = ((g % 5) == 4);
      exp_cnt = exp_l ? 3'd0 : 3'((g % 5) + 1);
      found   = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        tick(); #1;
        if (p_ack3 || l_ack3) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++; $display("FAIL starve_timeout grant %0d: got no ack want ack", g);
      end else begin
        total++; if (l_ack3 !== exp_l) begin bad++; $display("FAIL starve_order grant %0d: got l_ack=%b want %b", g, l_ack3, exp_l); end
        total++; if (u_dut3.starve_cnt_reg !== exp_cnt) begin bad++; $display("FAIL starve_cnt grant %0d: got %0d want %0d", g, u_dut3.starve_cnt_reg, exp_cnt); end
        $display("contested grant %0d: %s starve=%0d", g, l_ack3 ? "L" : "P", u_dut3.starve_cnt_reg);
      end
    end
    p_req3 = 1'b0; l_req3 = 1'b0;
  endtask

  task automatic test_p_during_l();
    tick();  // cycle 0
    l_req3 = 1'b1; l_we3 = 1'b0; l_addr3 = 32'h20;
    tick();  // cycle 1
    p_req3 = 1'b1; p_we3 = 1'b0; p_addr3 = 32'h20;
    #1;
    total++; if ({mem_en3, p_stall3, p_ack3} !== 3'b110) begin bad++; $display("FAIL pl_c1: got %b want 110", {mem_en3, p_stall3, p_ack3}); end
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      if (c < 4) begin
        total++; if ({p_stall3, p_ack3} !== 2'b10) begin bad++; $display("FAIL pl_wait c%0d: got %b want 10", c, {p_stall3, p_ack3}); end
      end else begin
        total++; if ({l_ack3, p_ack3, p_stall3} !== 3'b101) begin bad++; $display("FAIL pl_lack_c4: got %b want 101", {l_ack3, p_ack3, p_stall3}); end
        total++; if (rdata3 !== 32'h12345678) begin bad++; $display("FAIL pl_lrdata: got %h want 12345678", rdata3); end
      end
    end
    l_req3 = 1'b0;
    tick(); #1;  // cycle 5: IDLE, P still waiting
    total++; if ({busy3, p_stall3} !== 2'b01) begin bad++; $display("FAIL pl_idle_c5: got %b want 01", {busy3, p_stall3}); end
    for (int c = 6; c <= 9; c++) begin
      tick(); #1;
      if (c == 6) begin
        total++; if ({mem_en3, mem_we3, p_stall3} !== 3'b101) begin bad++; $display("FAIL pl_issue_c6: got %b want 101", {mem_en3, mem_we3, p_stall3}); end
      end
      if (c == 9) begin
        total++; if ({p_ack3, l_ack3, p_stall3} !== 3'b100) begin bad++; $display("FAIL pl_pack_c9: got %b want 100", {p_ack3, l_ack3, p_stall3}); end
      end
    end
    p_req3 = 1'b0;
    $display("P behind L: P acked cycle 9");
  endtask

  task automatic test_reset_mid_access();
    tick();  // cycle 0
    p_req3 = 1'b1; p_we3 = 1'b0; p_addr3 = 32'h20;
    tick(); #1;  // cycle 1
    total++; if (mem_en3 !== 1'b1) begin bad++; $display("FAIL rst_issue: got %b want 1", mem_en3); end
    tick();  // cycle 2: second ACCESS cycle
    rst = 1'b0;
    #1;
    total++; if ({mem_en3, mem_we3, p_ack3, l_ack3, busy3} !== 5'b0) begin bad++; $display("FAIL rst_ctrl: got %b want 00000", {mem_en3, mem_we3, p_ack3, l_ack3, busy3}); end
    total++; if ({mem_addr3, mem_wdata3, rdata3} !== 96'h0) begin bad++; $display("FAIL rst_data: got %h want 0", {mem_addr3, mem_wdata3, rdata3}); end
    tick(); #1;
    total++; if ({p_ack3, busy3} !== 2'b00) begin bad++; $display("FAIL rst_hold: got %b want 00", {p_ack3, busy3}); end
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      if (c == 1) begin
        total++; if ({mem_en3, busy3} !== 2'b11) begin bad++; $display("FAIL rst_regrant: got %b want 11", {mem_en3, busy3}); end
      end
      if (c < 4) begin
        total++; if (p_ack3 !== 1'b0) begin bad++; $display("FAIL rst_early_ack c%0d: got %b want 0", c, p_ack3); end
      end else begin
        total++; if ({p_ack3, rdata3} !== {1'b1, 32'h12345678}) begin bad++; $display("FAIL rst_ack: got %h want 112345678", {p_ack3, rdata3}); end
      end
    end
    p_req3 = 1'b0;
    $display("reset mid-access: re-granted with full latency");
  endtask

  task automatic test_early_drop();
    int en_cnt;
    int ack_cnt;
    en_cnt = 0; ack_cnt = 0;
    tick();  // cycle 0
    p_req3 = 1'b1; p_we3 = 1'b1; p_addr3 = 32'h50; p_wdata3 = 32'hCAFEF00D;
    tick();  // cycle 1
    p_req3 = 1'b0;
    #1;
    total++; if ({mem_en3, mem_we3, p_stall3} !== 3'b110) begin bad++; $display("FAIL drop_c1: got %b want 110", {mem_en3, mem_we3, p_stall3}); end
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      if (c == 4) begin
        total++; if (p_ack3 !== 1'b1) begin bad++; $display("FAIL drop_ack: got %b want 1", p_ack3); end
      end else begin
        total++; if (p_ack3 !== 1'b0) begin bad++; $display("FAIL drop_early_ack c%0d: got %b want 0", c, p_ack3); end
      end
    end
    for (int c = 5; c <= 10; c++) begin
      tick(); #1;
      if (mem_en3) en_cnt++;
      if (p_ack3 || l_ack3) ack_cnt++;
    end
    total++; if (en_cnt != 0 || ack_cnt != 0) begin bad++; $display("FAIL drop_reissue: got en=%0d ack=%0d want 0 0", en_cnt, ack_cnt); end
    total++; if (ram3[8'h50] !== 32'hCAFEF00D) begin bad++; $display("FAIL drop_write: got %h want cafef00d", ram3[8'h50]); end
    $display("P early drop: write 50 completed, acked once");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom1[i] = 32'h0;
    rom1[8'h10] = 32'hDEADBEEF;
    p_req1 = 1'b0; p_we1 = 1'b0; p_addr1 = '0; p_wdata1 = '0;
    l_req1 = 1'b0; l_we1 = 1'b0; l_addr1 = '0; l_wdata1 = '0;
    p_req3 = 1'b0; p_we3 = 1'b0; p_addr3 = '0; p_wdata3 = '0;
    l_req3 = 1'b0; l_we3 = 1'b0; l_addr3 = '0; l_wdata3 = '0;

    test_reset();
    test_p_read_lat1();
    test_l_write_p_read();
    test_starvation();
    test_p_during_l();
    test_reset_mid_access();
    test_early_drop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
